// File: rtl/all_pkgs.sv
`default_nettype none
// ============================================================================
//  all_pkgs
//  Shared width and fetch state encoding for the instruction fetch path.
//  Revision: 1.0
// ============================================================================
package all_pkgs;

    localparam int WIDTH = 32;

    // Byte distance between consecutive instruction words.
    localparam int INSTR_BYTES = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_HOLD = 3'd3,
        ST_DROP = 3'd4
    } fetch_state_t;

endpackage : all_pkgs
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  fetch_ctrl
//  Single-outstanding instruction fetch sequencer with stall hold and redirect.
//  Revision: 1.0
// ============================================================================
module fetch_ctrl
    import all_pkgs::*;
#(
    parameter int               WIDTH    = all_pkgs::WIDTH,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic             fetch_valid,
    output logic [WIDTH-1:0] fetch_pc,
    output logic [WIDTH-1:0] fetch_instr
);

    localparam logic [WIDTH-1:0] RESET_PC_ALIGNED = {RESET_PC[WIDTH-1:2], 2'b00};
    localparam logic [WIDTH-1:0] PC_STEP          = WIDTH'(INSTR_BYTES);

    fetch_state_t     state;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] hold_instr;
    logic [WIDTH-1:0] pc_seq;
    logic [WIDTH-1:0] redirect_target;
    logic             unused_redirect_lsbs;

    // pc only ever holds word-aligned values, so the address is the pc itself.
    assign pc_seq               = pc + PC_STEP;
    assign redirect_target      = {redirect_pc[WIDTH-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign imem_addr            = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            pc          <= RESET_PC_ALIGNED;
            hold_instr  <= '0;
            imem_req    <= 1'b0;
            fetch_valid <= 1'b0;
            fetch_pc    <= '0;
            fetch_instr <= '0;
        end else begin
            fetch_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    state    <= ST_REQ;
                    imem_req <= 1'b1;
                end

                ST_REQ: begin
                    if (redirect) begin
                        pc <= redirect_target;
                        // A grant in the redirect cycle still owes us a response.
                        if (imem_gnt) begin
                            state    <= ST_DROP;
                            imem_req <= 1'b0;
                        end
                    end else if (imem_gnt) begin
                        state    <= ST_WAIT;
                        imem_req <= 1'b0;
                    end
                end

                ST_WAIT: begin
                    if (redirect) begin
                        pc <= redirect_target;
                        if (imem_rvalid) begin
                            state    <= ST_REQ;
                            imem_req <= 1'b1;
                        end else begin
                            state <= ST_DROP;
                        end
                    end else if (imem_rvalid) begin
                        if (stall) begin
                            hold_instr <= imem_rdata;
                            state      <= ST_HOLD;
                        end else begin
                            fetch_valid <= 1'b1;
                            fetch_pc    <= pc;
                            fetch_instr <= imem_rdata;
                            pc          <= pc_seq;
                            state       <= ST_REQ;
                            imem_req    <= 1'b1;
                        end
                    end
                end

                ST_HOLD: begin
                    if (redirect) begin
                        pc         <= redirect_target;
                        hold_instr <= '0;
                        state      <= ST_REQ;
                        imem_req   <= 1'b1;
                    end else if (!stall) begin
                        fetch_valid <= 1'b1;
                        fetch_pc    <= pc;
                        fetch_instr <= hold_instr;
                        pc          <= pc_seq;
                        state       <= ST_REQ;
                        imem_req    <= 1'b1;
                    end
                end

                ST_DROP: begin
                    // Later redirects overwrite the target; the stale beat is still due.
                    if (redirect) begin
                        pc <= redirect_target;
                    end
                    if (imem_rvalid) begin
                        state    <= ST_REQ;
                        imem_req <= 1'b1;
                    end
                end

                default: begin
                    state    <= ST_IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule : fetch_ctrl
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  tb_fetch_ctrl
//  Directed vectors, corner sequences and a randomized stream check for fetch_ctrl.
//  Revision: 1.0
// ============================================================================
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_instr;

    int total = 0;
    int bad   = 0;

    fetch_ctrl #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .fetch_valid(fetch_valid),
        .fetch_pc   (fetch_pc),
        .fetch_instr(fetch_instr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        use_redir;
        logic [31:0] rpc;
        int          gnt_wait;
        int          rv_wait;
        int          stall_cycles;
        logic [31:0] data;
        logic [31:0] exp_addr;
        logic [31:0] exp_next;
    } vec_t;

    vec_t vecs[5];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!imem_req && n < 8) begin
            step();
            n++;
        end
        chk("req_wait", {31'd0, imem_req}, 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        do_reset();
        wait_req();
        if (v.use_redir) begin
            redirect = 1'b1; redirect_pc = v.rpc;
            step();
            redirect = 1'b0;
        end
        for (int k = 0; k < v.gnt_wait; k++) begin
            step();
            chk({tag, "_addr_stable"}, imem_addr, v.exp_addr);
        end
        chk({tag, "_addr"}, imem_addr, v.exp_addr);
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        chk({tag, "_req_low_wait"}, {31'd0, imem_req}, 32'd0);
        for (int k = 0; k < v.rv_wait; k++) step();
        imem_rvalid = 1'b1; imem_rdata = v.data;
        stall = (v.stall_cycles > 0);
        step();
        imem_rvalid = 1'b0; imem_rdata = 32'hFFFF_FFFF;
        for (int k = 1; k < v.stall_cycles; k++) begin
            chk({tag, "_no_valid_stall"}, {31'd0, fetch_valid}, 32'd0);
            step();
        end
        if (v.stall_cycles > 0) begin
            chk({tag, "_no_valid_stall"}, {31'd0, fetch_valid}, 32'd0);
            stall = 1'b0;
            step();
        end
        chk({tag, "_valid"}, {31'd0, fetch_valid}, 32'd1);
        chk({tag, "_pc"}, fetch_pc, v.exp_addr);
        chk({tag, "_instr"}, fetch_instr, v.data);
        chk({tag, "_next_req"}, {31'd0, imem_req}, 32'd1);
        chk({tag, "_next_addr"}, imem_addr, v.exp_next);
        step();
        chk({tag, "_pulse_one"}, {31'd0, fetch_valid}, 32'd0);
    endtask

    // Randomized stream: delivered pcs must follow the last redirect target in
    // steps of 4 and carry the memory word of that address.
    task automatic random_run(input int cycles);
        logic        pend = 1'b0;
        logic [31:0] pend_addr = '0;
        int          dly = 0;
        logic        d_gnt = 1'b0, d_rv = 1'b0, d_redir = 1'b0;
        logic [31:0] d_rpc = '0;
        logic        prev_req = 1'b0;
        logic [31:0] prev_addr = '0;
        logic [31:0] exp_pc = 32'h0;
        int          ndeliv = 0;
        do_reset();
        for (int c = 0; c < cycles; c++) begin
            step();
            if (d_rv) pend = 1'b0;
            if (d_gnt && prev_req) begin
                pend = 1'b1;
                pend_addr = prev_addr;
                dly = $urandom_range(0, 3);
            end
            if (fetch_valid) begin
                chk("rnd_pc", fetch_pc, exp_pc);
                chk("rnd_instr", fetch_instr, mem_word(fetch_pc));
                chk("rnd_valid_after_redirect", {31'd0, d_redir}, 32'd0);
                exp_pc = exp_pc + 32'd4;
                ndeliv++;
            end
            if (d_redir) exp_pc = {d_rpc[31:2], 2'b00};
            if (imem_req) begin
                chk("rnd_addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
                chk("rnd_one_outstanding", {31'd0, pend}, 32'd0);
                if (prev_req && !d_gnt && !d_redir)
                    chk("rnd_addr_hold", imem_addr, prev_addr);
            end
            d_rv = 1'b0;
            if (pend) begin
                if (dly == 0) d_rv = 1'b1;
                else dly--;
            end
            d_gnt   = imem_req && ($urandom_range(0, 2) != 0);
            d_redir = ($urandom_range(0, 9) == 0);
            d_rpc   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15))
                                                   : $urandom;
            prev_req  = imem_req;
            prev_addr = imem_addr;
            imem_gnt    = d_gnt;
            imem_rvalid = d_rv;
            imem_rdata  = d_rv ? mem_word(pend_addr) : $urandom;
            redirect    = d_redir;
            redirect_pc = d_rpc;
            stall       = ($urandom_range(0, 2) == 0);
        end
        chk("rnd_progress", {31'd0, ndeliv > 50}, 32'd1);
        imem_gnt = 1'b0; imem_rvalid = 1'b0; redirect = 1'b0; stall = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b0, 32'h0,         0, 1, 0, 32'h0050_0093, 32'h0000_0000, 32'h0000_0004};
        vecs[1] = '{1'b1, 32'h1000_0002, 2, 0, 0, 32'hDEAD_BEEF, 32'h1000_0000, 32'h1000_0004};
        vecs[2] = '{1'b0, 32'h0,         1, 0, 3, 32'h1234_5678, 32'h0000_0000, 32'h0000_0004};
        vecs[3] = '{1'b1, 32'hFFFF_FFFF, 0, 3, 1, 32'hA5A5_A5A5, 32'hFFFF_FFFC, 32'h0000_0000};
        vecs[4] = '{1'b1, 32'h0000_0203, 3, 1, 2, 32'h0000_0000, 32'h0000_0200, 32'h0000_0204};

        // Reset state
        do_reset();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, fetch_valid}, 32'd0);
        chk("rst_fetch_pc", fetch_pc, 32'd0);
        chk("rst_fetch_instr", fetch_instr, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // Four back-to-back zero-wait fetches
        do_reset();
        wait_req();
        for (int i = 0; i < 4; i++) begin
            chk("b2b_addr", imem_addr, 32'(4 * i));
            imem_gnt = 1'b1;
            step();
            imem_gnt = 1'b0;
            chk("b2b_req_low", {31'd0, imem_req}, 32'd0);
            imem_rvalid = 1'b1; imem_rdata = mem_word(32'(4 * i));
            step();
            imem_rvalid = 1'b0;
            chk("b2b_valid", {31'd0, fetch_valid}, 32'd1);
            chk("b2b_pc", fetch_pc, 32'(4 * i));
            chk("b2b_instr", fetch_instr, mem_word(32'(4 * i)));
        end

        // Redirect while waiting; stale data must be dropped
        do_reset();
        wait_req();
        imem_gnt = 1'b1; step(); imem_gnt = 1'b0;
        redirect = 1'b1; redirect_pc = 32'h100; step(); redirect = 1'b0;
        chk("drop_no_valid0", {31'd0, fetch_valid}, 32'd0);
        step();
        chk("drop_no_req", {31'd0, imem_req}, 32'd0);
        imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0; step(); imem_rvalid = 1'b0;
        chk("drop_no_valid1", {31'd0, fetch_valid}, 32'd0);
        chk("drop_req", {31'd0, imem_req}, 32'd1);
        chk("drop_addr", imem_addr, 32'h100);

        // Redirect with grant, then a second redirect while dropping
        do_reset();
        wait_req();
        imem_gnt = 1'b1; redirect = 1'b1; redirect_pc = 32'h200; step();
        imem_gnt = 1'b0; redirect_pc = 32'h300; step(); redirect = 1'b0;
        chk("dbl_no_req", {31'd0, imem_req}, 32'd0);
        imem_rvalid = 1'b1; imem_rdata = 32'hBAD1_BAD1; step(); imem_rvalid = 1'b0;
        chk("dbl_no_valid", {31'd0, fetch_valid}, 32'd0);
        chk("dbl_addr", imem_addr, 32'h300);

        // Asynchronous reset during WAIT, then a late response
        do_reset();
        wait_req();
        redirect = 1'b1; redirect_pc = 32'h40; step(); redirect = 1'b0;
        imem_gnt = 1'b1; step(); imem_gnt = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h1111_2222; step(); imem_rvalid = 1'b0;
        chk("arst_pre_pc", fetch_pc, 32'h40);
        imem_gnt = 1'b1; step(); imem_gnt = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_fetch_pc", fetch_pc, 32'd0);
        chk("arst_fetch_instr", fetch_instr, 32'd0);
        chk("arst_req", {31'd0, imem_req}, 32'd0);
        step();
        rst = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_0001;
        step();
        chk("late_rv_valid0", {31'd0, fetch_valid}, 32'd0);
        step();
        imem_rvalid = 1'b0;
        chk("late_rv_valid1", {31'd0, fetch_valid}, 32'd0);
        chk("late_rv_req", {31'd0, imem_req}, 32'd1);
        chk("late_rv_addr", imem_addr, 32'h0);

        random_run(4000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_fetch_ctrl
`default_nettype wire
